// File: rtl/demux1an_descp_param_if.sv
// Receive-path demux bus: serial word input side plus parallel lane outputs.
// The DUT takes the slave modport. The producer/consumer side takes master.
interface demux1an_descp_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned SEL_W = $clog2(N_OUT)
);

  logic                   valid;
  logic [WIDTH-1:0]       data_in;
  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_OUT*WIDTH-1:0] dataout;
  logic [N_OUT-1:0]       validout;
  logic [SEL_W-1:0]       lane_ptr;

  modport master (
    output valid,
    output data_in,
    output mode,
    output sel,
    input  dataout,
    input  validout,
    input  lane_ptr
  );

  modport slave (
    input  valid,
    input  data_in,
    input  mode,
    input  sel,
    output dataout,
    output validout,
    output lane_ptr
  );

endinterface

// File: rtl/demux1an_descp_param.sv
// 1-to-N word demultiplexer: group mode assembles N_OUT words round-robin and
// releases them together; direct mode routes each word to the lane named by sel.
module demux1an_descp_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned SEL_W = $clog2(N_OUT)
) (
  input logic                   clk_4f,
  input logic                   reset_L,
  demux1an_descp_param_if.slave bus
);

  localparam int unsigned      LAST     = N_OUT - 1;
  localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(N_OUT - 1);

  // The last word of a group bypasses staging and goes straight to its lane,
  // so only lanes 0..N_OUT-2 need a staging slot.
  logic [WIDTH-1:0]       staging_q [LAST];
  logic [WIDTH-1:0]       staging_d [LAST];
  logic [N_OUT*WIDTH-1:0] dataout_q,  dataout_d;
  logic [N_OUT-1:0]       validout_q, validout_d;
  logic [SEL_W-1:0]       lane_ptr_q, lane_ptr_d;

  // Next-state for staging, lane data, lane valids and group pointer
  always_comb begin
    staging_d  = staging_q;
    dataout_d  = dataout_q;
    validout_d = '0;
    lane_ptr_d = lane_ptr_q;

    if (!bus.mode) begin
      // Direct mode: any partial group is abandoned; out-of-range sel matches no lane
      lane_ptr_d = '0;
      if (bus.valid) begin
        for (int k = 0; k < int'(N_OUT); k++) begin
          if (bus.sel == SEL_W'(k)) begin
            dataout_d[k*WIDTH +: WIDTH] = bus.data_in;
            validout_d[k]               = 1'b1;
          end
        end
      end
    end else if (bus.valid) begin
      if (lane_ptr_q == LAST_PTR) begin
        for (int k = 0; k < int'(LAST); k++) begin
          dataout_d[k*WIDTH +: WIDTH] = staging_q[k];
        end
        dataout_d[LAST*WIDTH +: WIDTH] = bus.data_in;
        validout_d                     = '1;
        lane_ptr_d                     = '0;
      end else begin
        for (int k = 0; k < int'(LAST); k++) begin
          if (lane_ptr_q == SEL_W'(k)) begin
            staging_d[k] = bus.data_in;
          end
        end
        lane_ptr_d = lane_ptr_q + SEL_W'(1);
      end
    end
  end

  // State registers with synchronous active-low clear
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      for (int k = 0; k < int'(LAST); k++) begin
        staging_q[k] <= '0;
      end
      dataout_q  <= '0;
      validout_q <= '0;
      lane_ptr_q <= '0;
    end else begin
      staging_q  <= staging_d;
      dataout_q  <= dataout_d;
      validout_q <= validout_d;
      lane_ptr_q <= lane_ptr_d;
    end
  end

  assign bus.dataout  = dataout_q;
  assign bus.validout = validout_q;
  assign bus.lane_ptr = lane_ptr_q;

endmodule

// File: tb/tb_demux1an_descp_param.sv
// Bench for demux1an_descp_param: N_OUT=2,3,4 instances share one stimulus
// stream and are compared every cycle against a lane-array reference model.
module tb_demux1an_descp_param;

  localparam int unsigned WIDTH = 8;

  logic       clk_4f = 1'b0;
  logic       reset_L;
  logic       valid;
  logic [7:0] data_in;
  logic       mode;
  logic [2:0] sel;

  int checks = 0;
  int errors = 0;

  always #5 clk_4f = ~clk_4f;

  demux1an_descp_param_if #(.WIDTH(WIDTH), .N_OUT(2)) b2 ();
  demux1an_descp_param_if #(.WIDTH(WIDTH), .N_OUT(3)) b3 ();
  demux1an_descp_param_if #(.WIDTH(WIDTH), .N_OUT(4)) b4 ();

  assign b2.valid = valid;  assign b2.data_in = data_in;  assign b2.mode = mode;  assign b2.sel = sel[0:0];
  assign b3.valid = valid;  assign b3.data_in = data_in;  assign b3.mode = mode;  assign b3.sel = sel[1:0];
  assign b4.valid = valid;  assign b4.data_in = data_in;  assign b4.mode = mode;  assign b4.sel = sel[1:0];

  demux1an_descp_param #(.WIDTH(WIDTH), .N_OUT(2)) u_dut2 (.clk_4f(clk_4f), .reset_L(reset_L), .bus(b2.slave));
  demux1an_descp_param #(.WIDTH(WIDTH), .N_OUT(3)) u_dut3 (.clk_4f(clk_4f), .reset_L(reset_L), .bus(b3.slave));
  demux1an_descp_param #(.WIDTH(WIDTH), .N_OUT(4)) u_dut4 (.clk_4f(clk_4f), .reset_L(reset_L), .bus(b4.slave));

  // Reference state: pending group words and visible lane contents per instance
  int unsigned nlanes [3] = '{2, 3, 4};
  int unsigned m_ptr  [3];
  logic [7:0]  m_stage[3][8];
  logic [7:0]  m_lane [3][8];
  logic [7:0]  m_vld  [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int unsigned n;
      int unsigned s;
      n = nlanes[i];
      s = (i == 0) ? int'(sel) % 2 : int'(sel) % 4;
      m_vld[i] = '0;
      if (!reset_L) begin
        m_ptr[i] = 0;
        for (int k = 0; k < 8; k++) begin
          m_stage[i][k] = '0;
          m_lane[i][k]  = '0;
        end
      end else if (!mode) begin
        m_ptr[i] = 0;
        if (valid && s < n) begin
          m_lane[i][s] = data_in;
          m_vld[i][s]  = 1'b1;
        end
      end else if (valid) begin
        m_stage[i][m_ptr[i]] = data_in;
        m_ptr[i]++;
        if (m_ptr[i] == n) begin
          for (int k = 0; k < int'(n); k++) m_lane[i][k] = m_stage[i][k];
          m_vld[i] = 8'((1 << n) - 1);
          m_ptr[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      logic [63:0] exp_d;
      logic [63:0] got_d, got_v, got_p;
      exp_d = '0;
      for (int k = 0; k < int'(nlanes[i]); k++) exp_d[k*8 +: 8] = m_lane[i][k];
      got_d = (i == 0) ? 64'(b2.dataout)  : (i == 1) ? 64'(b3.dataout)  : 64'(b4.dataout);
      got_v = (i == 0) ? 64'(b2.validout) : (i == 1) ? 64'(b3.validout) : 64'(b4.validout);
      got_p = (i == 0) ? 64'(b2.lane_ptr) : (i == 1) ? 64'(b3.lane_ptr) : 64'(b4.lane_ptr);
      check($sformatf("%s/n%0d/dataout",  tag, nlanes[i]), got_d, exp_d);
      check($sformatf("%s/n%0d/validout", tag, nlanes[i]), got_v, 64'(m_vld[i]));
      check($sformatf("%s/n%0d/lane_ptr", tag, nlanes[i]), got_p, 64'(m_ptr[i]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk_4f);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d,
                       input logic m, input logic [2:0] s, input string tag);
    reset_L = r;
    valid   = v;
    data_in = d;
    mode    = m;
    sel     = s;
    tick(tag);
  endtask

  initial begin
    reset_L = 1'b0;
    valid   = 1'b1;
    data_in = 8'hFF;
    mode    = 1'b1;
    sel     = '0;

    // Reset with a live word on the input
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0, "reset0");
    drive(1'b0, 1'b1, 8'hFF, 1'b1, 3'd0, "reset1");
    check("reset/dataout",  64'(b4.dataout),  64'h0);
    check("reset/validout", 64'(b4.validout), 64'h0);
    check("reset/lane_ptr", 64'(b4.lane_ptr), 64'h0);

    // Two-lane group release, then data held with valids low
    drive(1'b1, 1'b1, 8'hA1, 1'b1, 3'd0, "grp2_a");
    drive(1'b1, 1'b1, 8'hB2, 1'b1, 3'd0, "grp2_b");
    check("grp2/dataout",  64'(b2.dataout),  64'hB2A1);
    check("grp2/validout", 64'(b2.validout), 64'h3);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, "grp2_idle");
    check("grp2/hold",     64'(b2.dataout),  64'hB2A1);
    check("grp2/vld_off",  64'(b2.validout), 64'h0);

    // Four-lane group with gaps
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, "grp4_rst");
    drive(1'b1, 1'b1, 8'h11, 1'b1, 3'd0, "grp4_11");
    drive(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, "grp4_gap");
    drive(1'b1, 1'b1, 8'h22, 1'b1, 3'd0, "grp4_22");
    drive(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, "grp4_gap");
    drive(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, "grp4_gap");
    drive(1'b1, 1'b1, 8'h33, 1'b1, 3'd0, "grp4_33");
    check("grp4/no_early", 64'(b4.validout), 64'h0);
    drive(1'b1, 1'b1, 8'h44, 1'b1, 3'd0, "grp4_44");
    check("grp4/dataout",  64'(b4.dataout),  64'h44332211);
    check("grp4/validout", 64'(b4.validout), 64'hF);

    // Direct routing
    drive(1'b1, 1'b1, 8'h5C, 1'b0, 3'd2, "dir_s2");
    check("dir/vld_s2", 64'(b4.validout), 64'h4);
    drive(1'b1, 1'b1, 8'h3D, 1'b0, 3'd0, "dir_s0");
    check("dir/vld_s0",  64'(b4.validout),        64'h1);
    check("dir/lane2",   64'(b4.dataout[23:16]), 64'h5C);

    // Reset aborts a partial group; the next four words form a clean group
    drive(1'b1, 1'b1, 8'hAA, 1'b1, 3'd0, "abort_a");
    drive(1'b1, 1'b1, 8'hBB, 1'b1, 3'd0, "abort_b");
    drive(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, "abort_rst");
    check("abort/validout", 64'(b4.validout), 64'h0);
    check("abort/lane_ptr", 64'(b4.lane_ptr), 64'h0);
    for (int w = 1; w <= 4; w++) drive(1'b1, 1'b1, 8'(w), 1'b1, 3'd0, "abort_grp");
    check("abort/release", 64'(b4.dataout),  64'h04030201);
    check("abort/vld",     64'(b4.validout), 64'hF);

    // Mode switch mid-group; the three-lane instance drops sel=3
    drive(1'b1, 1'b1, 8'h01, 1'b1, 3'd0, "sw_grp");
    drive(1'b1, 1'b1, 8'h77, 1'b0, 3'd3, "sw_dir");
    check("sw/validout", 64'(b4.validout),        64'h8);
    check("sw/lane3",    64'(b4.dataout[31:24]), 64'h77);
    check("sw/lane_ptr", 64'(b4.lane_ptr),       64'h0);
    check("sw/n3_drop",  64'(b3.validout),       64'h0);

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      logic r, v, m;
      r = ($urandom % 60) != 0;
      v = ($urandom % 4) != 0;
      m = (($urandom % 12) == 0) ? ~mode : mode;
      drive(r, v, 8'($urandom), m, 3'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
